// File: rtl/delay_line_pkg.sv
// Shared types and default widths for the delay-line capture/playback controller.
package delay_line_pkg;

   localparam int CNT_W_DEF = 16;
   localparam int OVF_W_DEF = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CAPTURE = 3'd1,
      ST_WAIT    = 3'd2,
      ST_PLAY    = 3'd3,
      ST_GUARD   = 3'd4
   } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer with rising-edge detect. Edges are only reported once a
// genuine low has been sampled after reset, so a line already high at release is ignored.
module sync_edge_detect (
   input  logic clk,
   input  logic n_reset,
   input  logic async_in,
   output logic rise
);

   logic       meta_reg;
   logic       sync_reg;
   logic       prev_reg;
   logic       armed_reg;
   logic [1:0] fill_reg;

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         meta_reg  <= 1'b0;
         sync_reg  <= 1'b0;
         prev_reg  <= 1'b0;
         armed_reg <= 1'b0;
         fill_reg  <= 2'b00;
      end else begin
         meta_reg <= async_in;
         sync_reg <= meta_reg;
         prev_reg <= sync_reg;
         fill_reg <= {fill_reg[0], 1'b1};
         // fill_reg[1] marks sync_reg as holding a real post-reset sample
         if (fill_reg[1] && !sync_reg)
            armed_reg <= 1'b1;
      end
   end

   assign rise = sync_reg & ~prev_reg & armed_reg;

endmodule

// File: rtl/delay_line_ctrl.sv
// Capture / wait / playback / guard sequencer for an external delay line,
// timed by one shared down-counter, with a saturating count of lost triggers.
module delay_line_ctrl
   import delay_line_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int OVF_W = OVF_W_DEF
) (
   input  logic             clk,
   input  logic             n_reset,
   input  logic             ctrl_en,
   input  logic             in_sig,
   input  logic [CNT_W-1:0] cfg_len,
   input  logic [CNT_W-1:0] cfg_delay,
   input  logic [CNT_W-1:0] cfg_guard,
   output logic             cap_en,
   output logic             play_en,
   output logic             out_en,
   output logic             busy,
   output logic             overrun,
   output logic [OVF_W-1:0] overrun_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             trigger;
   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [CNT_W-1:0] len_reg, delay_reg, guard_reg;
   logic             load_cfg;
   logic             cap_en_reg, play_en_reg, out_en_reg, busy_reg, overrun_reg;
   logic [OVF_W-1:0] overrun_cnt_reg;

   sync_edge_detect u_sync (
      .clk      (clk),
      .n_reset  (n_reset),
      .async_in (in_sig),
      .rise     (trigger)
   );

   // Counter is loaded on every state entry and the state exits when it reads 1.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      load_cfg   = 1'b0;
      if (!ctrl_en) begin
         state_next = ST_IDLE;
         cnt_next   = '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (trigger && (cfg_len != '0)) begin
                  state_next = ST_CAPTURE;
                  cnt_next   = cfg_len;
                  load_cfg   = 1'b1;
               end
            end
            ST_CAPTURE: begin
               if (cnt_reg == CNT_ONE) begin
                  if (delay_reg != '0) begin
                     state_next = ST_WAIT;
                     cnt_next   = delay_reg;
                  end else begin
                     state_next = ST_PLAY;
                     cnt_next   = len_reg;
                  end
               end else begin
                  cnt_next = cnt_reg - CNT_ONE;
               end
            end
            ST_WAIT: begin
               if (cnt_reg == CNT_ONE) begin
                  state_next = ST_PLAY;
                  cnt_next   = len_reg;
               end else begin
                  cnt_next = cnt_reg - CNT_ONE;
               end
            end
            ST_PLAY: begin
               if (cnt_reg == CNT_ONE) begin
                  if (guard_reg != '0) begin
                     state_next = ST_GUARD;
                     cnt_next   = guard_reg;
                  end else begin
                     state_next = ST_IDLE;
                     cnt_next   = '0;
                  end
               end else begin
                  cnt_next = cnt_reg - CNT_ONE;
               end
            end
            ST_GUARD: begin
               if (cnt_reg == CNT_ONE) begin
                  state_next = ST_IDLE;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg - CNT_ONE;
               end
            end
            default: begin
               state_next = ST_IDLE;
               cnt_next   = '0;
            end
         endcase
      end
   end

   // Enables are registered alongside the state so they line up with it exactly.
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state_reg       <= ST_IDLE;
         cnt_reg         <= '0;
         len_reg         <= '0;
         delay_reg       <= '0;
         guard_reg       <= '0;
         cap_en_reg      <= 1'b0;
         play_en_reg     <= 1'b0;
         out_en_reg      <= 1'b0;
         busy_reg        <= 1'b0;
         overrun_reg     <= 1'b0;
         overrun_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         if (load_cfg) begin
            len_reg   <= cfg_len;
            delay_reg <= cfg_delay;
            guard_reg <= cfg_guard;
         end
         cap_en_reg  <= (state_next == ST_CAPTURE);
         play_en_reg <= (state_next == ST_PLAY);
         out_en_reg  <= (state_next == ST_PLAY);
         busy_reg    <= (state_next != ST_IDLE);
         // A trigger that arrives while not idle (including the last guard cycle) is lost.
         if (trigger && (state_reg != ST_IDLE)) begin
            overrun_reg <= 1'b1;
            if (overrun_cnt_reg != {OVF_W{1'b1}})
               overrun_cnt_reg <= overrun_cnt_reg + {{(OVF_W-1){1'b0}}, 1'b1};
         end else begin
            overrun_reg <= 1'b0;
         end
      end
   end

   assign cap_en      = cap_en_reg;
   assign play_en     = play_en_reg;
   assign out_en      = out_en_reg;
   assign busy        = busy_reg;
   assign overrun     = overrun_reg;
   assign overrun_cnt = overrun_cnt_reg;

endmodule

// File: doc/delay_line_ctrl.md
DELAY_LINE_CTRL -- requirements
Module: delay_line_ctrl

Interface
REQ-001 Parameter CNT_W, 16, width of length/delay/guard counters and config inputs.
REQ-002 Parameter OVF_W, 8, width of saturating overrun counter.
REQ-003 clk  input  1  single system clock (PLL output); all logic on rising edge.
REQ-004 n_reset  input  1  reset, synchronous and active-low.
REQ-005 ctrl_en  input  1  controller enable; low forces IDLE.
REQ-006 in_sig  input  1  asynchronous line input; trigger source.
REQ-007 cfg_len  input  CNT_W  capture/playback length in cycles.
REQ-008 cfg_delay  input  CNT_W  cycles between capture end and playback start.
REQ-009 cfg_guard  input  CNT_W  turnaround cycles after playback before re-arming.
REQ-010 cap_en  output  1  delay-line write enable (capture window).
REQ-011 play_en  output  1  delay-line read enable (playback window).
REQ-012 out_en  output  1  line driver enable for the tristate output.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 overrun  output  1  one-cycle pulse on a trigger lost while busy.
REQ-015 overrun_cnt  output  OVF_W  saturating count of overrun pulses.

Function
REQ-016 in_sig SHALL pass a 2-flop synchronizer; trigger = synchronized value 1 while previous synchronized value 0 (rising edge).
REQ-017 FSM states SHALL be IDLE, CAPTURE, WAIT, PLAY, GUARD.
REQ-018 IDLE: on trigger with ctrl_en=1 and cfg_len!=0, latch cfg_len/cfg_delay/cfg_guard and enter CAPTURE next cycle; with cfg_len=0, ignore trigger, stay IDLE, no overrun.
REQ-019 Config inputs SHALL be sampled only on the IDLE->CAPTURE transition; later changes do not affect the frame in flight.
REQ-020 CAPTURE: cap_en=1 for exactly latched len cycles, then WAIT if delay!=0, else PLAY directly.
REQ-021 WAIT: all enables 0 for exactly latched delay cycles, then PLAY.
REQ-022 PLAY: play_en=1 and out_en=1 for exactly latched len cycles, then GUARD if guard!=0, else IDLE.
REQ-023 GUARD: all enables 0 for exactly latched guard cycles, then IDLE.
REQ-024 cap_en, play_en, out_en SHALL be registered, decoded from the current state only; never two asserted with cap_en simultaneously.
REQ-025 Trigger in any state other than IDLE SHALL produce overrun=1 for one cycle and increment overrun_cnt, saturating at 2^OVF_W-1; frame continues unaffected.
REQ-026 Trigger on the same cycle GUARD ends SHALL count as overrun, not a new frame; re-arm takes effect from the first IDLE cycle.
REQ-027 ctrl_en=0 in any state SHALL enter IDLE next cycle with all enables 0; overrun_cnt retained.
REQ-028 Latency: in_sig rising edge to first cap_en=1 cycle SHALL be 3-4 clk cycles (synchronizer uncertainty).
REQ-029 A single counter of width CNT_W SHALL time all states, loaded on each state entry and counting down to 1.

Reset
REQ-030 With n_reset=0 at a clock edge: state IDLE, cap_en=play_en=out_en=busy=overrun=0, overrun_cnt=0, synchronizer flops and latched config 0.
REQ-031 Reset asserted mid-frame SHALL drop out_en on the next edge; no trigger is recognized on the first cycle after reset release (edge detector history cleared to 0 ⇒ in_sig already high gives trigger only after going low then high).

Structure
REQ-032 Shared package delay_line_pkg SHALL hold the state enumeration typedef and default CNT_W/OVF_W constants.
REQ-033 Sub-module sync_edge_detect (2-flop synchronizer plus rising-edge detect, synchronous active-low reset) SHALL be instantiated once.
REQ-034 Total RTL: one FSM, one down-counter, one saturating counter; no memories.

Verification
REQ-035 len=4, delay=2, guard=3, pulse in_sig: cap_en high 4 cycles, 2 idle cycles, play_en=out_en high 4 cycles, 3 guard cycles, busy falls; 13 busy cycles total.
REQ-036 len=5, delay=0, guard=0: PLAY immediately follows CAPTURE, IDLE immediately follows PLAY; busy exactly 10 cycles.
REQ-037 len=0, pulse in_sig: busy stays 0, overrun stays 0.
REQ-038 len=8, second in_sig edge during PLAY: overrun pulses once, overrun_cnt 0->1, out_en still high 8 cycles; 300 edges while busy with OVF_W=8: overrun_cnt holds at 255.
REQ-039 Change cfg_len 4->10 during CAPTURE: current frame still captures/plays 4 cycles; next frame uses 10.
REQ-040 ctrl_en dropped and separately n_reset asserted during PLAY: out_en=0 next cycle, state IDLE; in_sig held high across reset release yields no frame until a new rising edge.
